uart_cmd_decoder: RTL and testbench



---
 rtl/uart_cmd_pkg.sv | 50 +++++
 rtl/uart_cmd_decoder_handshake.sv | 48 ++++
 rtl/uart_cmd_decoder.sv | 159 +++++++++++++++
 tb/tb_uart_cmd_decoder.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_cmd_pkg.sv
// Shared opcodes, state encodings and opcode-class helpers for the UART command decoder.
package uart_cmd_pkg;

  localparam logic [7:0] OPC_NOP   = 8'h00;
  localparam logic [7:0] OPC_WRITE = 8'h01;
  localparam logic [7:0] OPC_READ  = 8'h02;
  localparam logic [7:0] OPC_EXEC  = 8'h03;
  localparam logic [7:0] OPC_PING  = 8'h50;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_OP_WAIT,
    ST_OP_DRAIN,
    ST_DECODE,
    ST_ARG_REQ,
    ST_ARG_WAIT,
    ST_ARG_DRAIN,
    ST_CMD_OUT,
    ST_RSP_WAIT,
    ST_WR_REQ,
    ST_WR_WAIT,
    ST_WR_DRAIN
  } state_e;

  typedef enum logic [1:0] {
    HS_IDLE,
    HS_WAIT,
    HS_DRAIN
  } hs_phase_e;

  typedef struct packed {
    logic [7:0]  opcode;
    logic [23:0] imm;
    logic [31:0] arg;
  } cmd_t;

  function automatic logic op_has_arg(input logic [7:0] op);
    return (op == OPC_WRITE) || (op == OPC_EXEC);
  endfunction

  function automatic logic op_has_rsp(input logic [7:0] op);
    return (op == OPC_READ) || (op == OPC_EXEC);
  endfunction

  // Opcodes that are forwarded to the controller core.
  function automatic logic op_is_core(input logic [7:0] op);
    return (op == OPC_WRITE) || (op == OPC_READ) || (op == OPC_EXEC);
  endfunction

endpackage

// File: rtl/uart_cmd_decoder_handshake.sv
// Pulse/wait/drain sequencer for a UART port whose completion strobe lasts two cycles.
module uart_word_handshake
  import uart_cmd_pkg::*;
(
  input  logic clk,
  input  logic resetn,
  input  logic start,
  input  logic response,
  output logic req,
  output logic got,
  output logic busy
);

  hs_phase_e phase_q, phase_d;
  logic      req_d;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      phase_q <= HS_IDLE;
      req     <= 1'b0;
    end else begin
      phase_q <= phase_d;
      req     <= req_d;
    end
  end

  // got marks the first response cycle, the only one on which read data is valid.
  always_comb begin
    phase_d = phase_q;
    req_d   = 1'b0;
    got     = 1'b0;
    case (phase_q)
      HS_IDLE: if (start) begin
        req_d   = 1'b1;
        phase_d = HS_WAIT;
      end
      HS_WAIT: if (response) begin
        got     = 1'b1;
        phase_d = HS_DRAIN;
      end
      HS_DRAIN: if (!response) phase_d = HS_IDLE;
      default: phase_d = HS_IDLE;
    endcase
  end

  assign busy = (phase_q != HS_IDLE);

endmodule

// File: rtl/uart_cmd_decoder.sv
// Parses UART words into controller commands and writes local or core responses back to the host.
module uart_cmd_decoder
  import uart_cmd_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 25000000,
  parameter logic [31:0] PING_ID        = 32'h50494E47,
  parameter logic [31:0] ERR_WORD       = 32'hFFFFFFFF
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        uart_rx_empty,
  output logic        uart_read,
  input  logic        uart_read_response,
  input  logic [31:0] uart_read_data,
  output logic        uart_write,
  input  logic        uart_write_response,
  output logic [31:0] uart_write_data,
  output logic        cmd_valid,
  input  logic        cmd_ready,
  output logic [7:0]  cmd_opcode,
  output logic [23:0] cmd_imm,
  output logic [31:0] cmd_arg,
  input  logic        rsp_valid,
  output logic        rsp_ready,
  input  logic [31:0] rsp_data,
  output logic [7:0]  err_count
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  state_e        state_q, state_d;
  cmd_t          cmd_q;
  logic [TW-1:0] tmo_q;
  logic [7:0]    err_q;
  logic [31:0]   wr_word_q, wr_word_d;
  logic          wr_load, err_inc;
  logic          rd_start, rd_got, rd_busy;
  logic          wr_start, wr_got, wr_busy;

  uart_word_handshake u_rd_hs (
    .clk      (clk),
    .resetn   (resetn),
    .start    (rd_start),
    .response (uart_read_response),
    .req      (uart_read),
    .got      (rd_got),
    .busy     (rd_busy)
  );

  uart_word_handshake u_wr_hs (
    .clk      (clk),
    .resetn   (resetn),
    .start    (wr_start),
    .response (uart_write_response),
    .req      (uart_write),
    .got      (wr_got),
    .busy     (wr_busy)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    rd_start  = 1'b0;
    wr_start  = 1'b0;
    wr_load   = 1'b0;
    wr_word_d = ERR_WORD;
    err_inc   = 1'b0;
    case (state_q)
      ST_IDLE: if (!uart_rx_empty && !rd_busy) begin
        rd_start = 1'b1;
        state_d  = ST_OP_WAIT;
      end
      ST_OP_WAIT:  if (rd_got)   state_d = ST_OP_DRAIN;
      ST_OP_DRAIN: if (!rd_busy) state_d = ST_DECODE;
      ST_DECODE: begin
        if (cmd_q.opcode == OPC_NOP) begin
          state_d = ST_IDLE;
        end else if (cmd_q.opcode == OPC_PING) begin
          wr_load   = 1'b1;
          wr_word_d = PING_ID;
          state_d   = ST_WR_REQ;
        end else if (!op_is_core(cmd_q.opcode)) begin
          wr_load = 1'b1;
          err_inc = 1'b1;
          state_d = ST_WR_REQ;
        end else if (op_has_arg(cmd_q.opcode)) begin
          state_d = ST_ARG_REQ;
        end else begin
          state_d = ST_CMD_OUT;
        end
      end
      // An available argument word wins over a timeout expiring on the same cycle.
      ST_ARG_REQ: begin
        if (!uart_rx_empty && !rd_busy) begin
          rd_start = 1'b1;
          state_d  = ST_ARG_WAIT;
        end else if (tmo_q == TMO_LAST) begin
          wr_load = 1'b1;
          err_inc = 1'b1;
          state_d = ST_WR_REQ;
        end
      end
      ST_ARG_WAIT:  if (rd_got)   state_d = ST_ARG_DRAIN;
      ST_ARG_DRAIN: if (!rd_busy) state_d = ST_CMD_OUT;
      ST_CMD_OUT: if (cmd_ready) begin
        state_d = op_has_rsp(cmd_q.opcode) ? ST_RSP_WAIT : ST_IDLE;
      end
      ST_RSP_WAIT: if (rsp_valid) begin
        wr_load   = 1'b1;
        wr_word_d = rsp_data;
        state_d   = ST_WR_REQ;
      end
      ST_WR_REQ: if (!wr_busy) begin
        wr_start = 1'b1;
        state_d  = ST_WR_WAIT;
      end
      ST_WR_WAIT:  if (wr_got)   state_d = ST_WR_DRAIN;
      ST_WR_DRAIN: if (!wr_busy) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // wr_word_q is only reloaded outside the write states, so the UART sees a stable word.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cmd_q     <= '0;
      tmo_q     <= '0;
      err_q     <= '0;
      wr_word_q <= '0;
    end else begin
      if (state_q == ST_OP_WAIT && rd_got) begin
        cmd_q.opcode <= uart_read_data[31:24];
        cmd_q.imm    <= uart_read_data[23:0];
      end
      if (state_q == ST_DECODE) begin
        cmd_q.arg <= '0;
        tmo_q     <= '0;
      end
      if (state_q == ST_ARG_REQ) tmo_q <= tmo_q + 1'b1;
      if (state_q == ST_ARG_WAIT && rd_got) cmd_q.arg <= uart_read_data;
      if (wr_load) wr_word_q <= wr_word_d;
      if (err_inc && err_q != 8'hFF) err_q <= err_q + 8'd1;
    end
  end

  assign cmd_valid       = (state_q == ST_CMD_OUT);
  assign rsp_ready       = (state_q == ST_RSP_WAIT);
  assign cmd_opcode      = cmd_q.opcode;
  assign cmd_imm         = cmd_q.imm;
  assign cmd_arg         = cmd_q.arg;
  assign uart_write_data = wr_word_q;
  assign err_count       = err_q;

endmodule

// File: tb/tb_uart_cmd_decoder.sv
// Directed bench: UART read/write responders driven on the falling edge, core driven by the test sequence.
module tb_uart_cmd_decoder;

  localparam int unsigned TMO      = 100;
  localparam logic [31:0] PING_ID  = 32'h50494E47;
  localparam logic [31:0] ERR_WORD = 32'hFFFFFFFF;

  logic        clk, resetn;
  logic        uart_rx_empty, uart_read, uart_read_response;
  logic [31:0] uart_read_data;
  logic        uart_write, uart_write_response;
  logic [31:0] uart_write_data;
  logic        cmd_valid, cmd_ready;
  logic [7:0]  cmd_opcode;
  logic [23:0] cmd_imm;
  logic [31:0] cmd_arg;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_data;
  logic [7:0]  err_count;

  int checks = 0, errors = 0;
  logic [31:0] rxq[$];
  logic [31:0] wq[$];
  int cyc = 0, rd_cyc = 0, wr_cyc = 0;
  int rd_pulses = 0, rd_hi = 0, wr_hi = 0, rd_viol = 0, cmdv_cyc = 0;
  int rd_ph = 0, wr_ph = 0;
  bit rd_stall = 0;

  uart_cmd_decoder #(.TIMEOUT_CYCLES(TMO), .PING_ID(PING_ID), .ERR_WORD(ERR_WORD)) dut (
    .clk                 (clk),
    .resetn              (resetn),
    .uart_rx_empty       (uart_rx_empty),
    .uart_read           (uart_read),
    .uart_read_response  (uart_read_response),
    .uart_read_data      (uart_read_data),
    .uart_write          (uart_write),
    .uart_write_response (uart_write_response),
    .uart_write_data     (uart_write_data),
    .cmd_valid           (cmd_valid),
    .cmd_ready           (cmd_ready),
    .cmd_opcode          (cmd_opcode),
    .cmd_imm             (cmd_imm),
    .cmd_arg             (cmd_arg),
    .rsp_valid           (rsp_valid),
    .rsp_ready           (rsp_ready),
    .rsp_data            (rsp_data),
    .err_count           (err_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // UART model: response strobes last two cycles, read data valid only on the first.
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (cmd_valid)  cmdv_cyc++;
      if (uart_read)  rd_hi++;
      if (uart_write) wr_hi++;
      if (!resetn) begin
        rd_ph = 0; wr_ph = 0;
        uart_read_response = 1'b0; uart_write_response = 1'b0;
      end else begin
        if (rd_ph == 1) begin
          rd_ph = 2; uart_read_data = 32'hA5A5A5A5;
        end else if (rd_ph == 2) begin
          rd_ph = 0; uart_read_response = 1'b0; uart_read_data = '0;
        end else if (uart_read) begin
          rd_pulses++; rd_cyc = cyc;
          if (rxq.size() == 0) rd_viol++;
          else if (!rd_stall) begin
            uart_read_data = rxq.pop_front(); uart_read_response = 1'b1; rd_ph = 1;
          end
        end
        if (wr_ph == 1) wr_ph = 2;
        else if (wr_ph == 2) begin
          wr_ph = 0; uart_write_response = 1'b0;
        end else if (uart_write) begin
          wq.push_back(uart_write_data); wr_cyc = cyc;
          uart_write_response = 1'b1; wr_ph = 1;
        end
      end
      uart_rx_empty = (rxq.size() == 0);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic expect_write(input string tag, input logic [31:0] exp);
    int n = 0;
    while (wq.size() == 0 && n < 400) begin @(negedge clk); n++; end
    chk({tag, "_seen"}, wq.size() != 0, 1);
    if (wq.size() != 0) chk(tag, wq.pop_front(), exp);
  endtask

  task automatic wait_rd_pulse(input string tag, input int p0);
    int n = 0;
    while (rd_pulses == p0 && n < 400) begin @(negedge clk); n++; end
    chk(tag, rd_pulses - p0, 1);
  endtask

  task automatic cmd_accept(input string tag, input logic [7:0] op, input logic [23:0] imm,
                            input logic [31:0] arg, input int hold);
    int n = 0;
    while (!cmd_valid && n < 400) begin @(negedge clk); n++; end
    chk({tag, "_valid"}, cmd_valid, 1);
    chk({tag, "_fields"}, {cmd_opcode, cmd_imm, cmd_arg}, {op, imm, arg});
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk({tag, "_hold"}, {cmd_valid, rsp_ready, cmd_opcode, cmd_imm, cmd_arg},
          {1'b1, 1'b0, op, imm, arg});
    end
    cmd_ready = 1'b1;
    @(negedge clk);
    cmd_ready = 1'b0;
    chk({tag, "_done"}, cmd_valid, 0);
  endtask

  initial begin
    int v0, w0, p0, n, bad;
    resetn = 1'b0; uart_rx_empty = 1'b1; uart_read_response = 1'b0; uart_read_data = '0;
    uart_write_response = 1'b0; cmd_ready = 1'b0; rsp_valid = 1'b0; rsp_data = '0;
    tick(3);
    chk("rst_ctrl", {uart_read, uart_write, cmd_valid, rsp_ready, err_count}, 0);
    chk("rst_data", {uart_write_data, cmd_opcode, cmd_imm, cmd_arg}, 0);
    resetn = 1'b1;
    tick(2);

    // PING answered locally
    v0 = cmdv_cyc; w0 = wr_hi;
    rxq.push_back(32'h50000000);
    expect_write("ping_word", PING_ID);
    tick(6);
    chk("ping_pulses", wr_hi - w0, 1);
    chk("ping_nocmd", cmdv_cyc - v0, 0);

    // WRITE with argument, no response
    w0 = wr_hi;
    rxq.push_back(32'h01000010);
    rxq.push_back(32'hDEADBEEF);
    cmd_accept("wr", 8'h01, 24'h000010, 32'hDEADBEEF, 0);
    tick(10);
    chk("wr_nowrite", wr_hi - w0, 0);
    chk("wr_rsp_ready", rsp_ready, 0);

    // READ with back-pressure then core response
    rxq.push_back(32'h02000004);
    cmd_accept("rd", 8'h02, 24'h000004, 32'h0, 5);
    rsp_data = 32'h12345678; rsp_valid = 1'b1;
    n = 0;
    while (!rsp_ready && n < 50) begin @(negedge clk); n++; end
    chk("rd_rsp_ready", rsp_ready, 1);
    @(negedge clk);
    rsp_valid = 1'b0;
    chk("rd_rsp_drop", rsp_ready, 0);
    expect_write("rd_word", 32'h12345678);

    // Unknown opcode
    rxq.push_back(32'h7F000000);
    expect_write("unk_word", ERR_WORD);
    chk("unk_err", err_count, 1);

    // Argument timeout: opcode read at N0, write pulse observed at N106
    tick(4);
    v0 = cmdv_cyc;
    rxq.push_back(32'h03000000);
    expect_write("tmo_word", ERR_WORD);
    chk("tmo_lat", wr_cyc - rd_cyc, 106);
    chk("tmo_nocmd", cmdv_cyc - v0, 0);
    chk("tmo_err", err_count, 2);

    // Saturation: 300 errors in total
    tick(4);
    for (int i = 0; i < 298; i++) rxq.push_back(32'h7F000000);
    n = 0;
    while (wq.size() < 298 && n < 9000) begin @(negedge clk); n++; end
    chk("sat_writes", wq.size(), 298);
    bad = 0;
    foreach (wq[i]) if (wq[i] !== ERR_WORD) bad++;
    chk("sat_words", bad, 0);
    chk("sat_err", err_count, 8'hFF);
    wq.delete();
    tick(6);

    // Reset while waiting for an argument word
    p0 = rd_pulses;
    rxq.push_back(32'h03000010);
    wait_rd_pulse("arg_op_rd", p0);
    rd_stall = 1;
    p0 = rd_pulses;
    rxq.push_back(32'hCAFEF00D);
    wait_rd_pulse("arg_rd", p0);
    tick(3);
    chk("pre_rst_op", {cmd_opcode, cmd_imm}, {8'h03, 24'h000010});
    #2 resetn = 1'b0;
    #1;
    chk("arst_ctrl", {uart_read, uart_write, cmd_valid, rsp_ready, err_count}, 0);
    chk("arst_data", {uart_write_data, cmd_opcode, cmd_imm, cmd_arg}, 0);
    rxq.delete();
    rd_stall = 0;
    tick(3);
    resetn = 1'b1;
    tick(2);

    v0 = cmdv_cyc; w0 = wr_hi; p0 = rd_pulses;
    rxq.push_back(32'h00000000);
    wait_rd_pulse("nop_rd", p0);
    tick(8);
    chk("nop_nocmd", cmdv_cyc - v0, 0);
    chk("nop_nowr", wr_hi - w0, 0);
    rxq.push_back(32'h50000000);
    expect_write("post_rst_ping", PING_ID);
    chk("post_rst_err", err_count, 0);
    chk("rd_empty_viol", rd_viol, 0);
    chk("rd_pulse_len", rd_hi, rd_pulses);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
